// File: rtl/aes128_decrypt_iter_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the iterative AES-128 decrypt core.
package aes128_decrypt_iter_pkg;

   localparam int NR      = 10;
   localparam int BLK_W   = 128;
   localparam int SCHED_W = (NR + 1) * BLK_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2
   } fsm_e;

   // Inverse S-box, entry 0 in the top byte.
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX[2047 - 8 * int'(b) -: 8];
   endfunction

   // Multiply by x modulo 0x11B.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm09(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gm0b(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gm0d(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gm0e(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse cipher round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the last round. Byte k of a block sits in bits [127-8k -: 8].
module aes_inv_round
   import aes128_decrypt_iter_pkg::*;
(
   input  logic [BLK_W-1:0] state_i,
   input  logic [BLK_W-1:0] rk_i,
   input  logic             final_i,
   output logic [BLK_W-1:0] state_o
);

   logic [BLK_W-1:0] ark_w;
   logic [BLK_W-1:0] mixed_w;

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {gm0e(a0) ^ gm0b(a1) ^ gm0d(a2) ^ gm09(a3),
              gm09(a0) ^ gm0e(a1) ^ gm0b(a2) ^ gm0d(a3),
              gm0d(a0) ^ gm09(a1) ^ gm0e(a2) ^ gm0b(a3),
              gm0b(a0) ^ gm0d(a1) ^ gm09(a2) ^ gm0e(a3)};
   endfunction

   // Row r rotates right by r columns: output (c,r) takes input column (c-r) mod 4, then S-box and key.
   always_comb begin
      ark_w = '0;
      for (int i = 0; i < 16; i++) begin
         ark_w[127 - 8*i -: 8] =
            inv_sbox(state_i[127 - 8*(4*(((i/4) + 4 - (i%4)) % 4) + (i%4)) -: 8]) ^
            rk_i[127 - 8*i -: 8];
      end
   end

   // Column-wise InvMixColumns on the key-added state.
   always_comb begin
      mixed_w = '0;
      for (int c = 0; c < 4; c++) begin
         mixed_w[127 - 32*c -: 32] = inv_mix_col(ark_w[127 - 32*c -: 32]);
      end
   end

   assign state_o = final_i ? ark_w : mixed_w;

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryption: initial key add on start, nine full inverse rounds,
// one final round without InvMixColumns, then a one-cycle done pulse.
module aes128_decrypt_iter
   import aes128_decrypt_iter_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [BLK_W-1:0]   ciphertext,
   input  logic [SCHED_W-1:0] round_keys,
   output logic [BLK_W-1:0]   plaintext,
   output logic               busy,
   output logic               done
);

   fsm_e             fsm_q;
   logic [3:0]       rnd_q;
   logic [BLK_W-1:0] state_q;
   logic [BLK_W-1:0] pt_q;
   logic             busy_q;
   logic             done_q;

   logic [3:0]       rk_idx;
   logic [BLK_W-1:0] rk_sel;
   logic [BLK_W-1:0] round_d;
   logic             last_rnd;

   assign last_rnd = (fsm_q == ST_FINAL);
   assign rk_idx   = last_rnd ? 4'd0 : rnd_q;

   // Round-key mux; indices beyond the schedule select nothing rather than reading out of range.
   always_comb begin
      rk_sel = '0;
      for (int r = 0; r <= NR; r++) begin
         if (int'(rk_idx) == r) rk_sel = round_keys[SCHED_W - 1 - BLK_W*r -: BLK_W];
      end
   end

   aes_inv_round u_round (
      .state_i (state_q),
      .rk_i    (rk_sel),
      .final_i (last_rnd),
      .state_o (round_d)
   );

   // Control FSM with registered busy/done/plaintext; reset discards any block in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q   <= ST_IDLE;
         rnd_q   <= '0;
         state_q <= '0;
         pt_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (fsm_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ciphertext ^ round_keys[BLK_W-1:0];
                  rnd_q   <= 4'(NR - 1);
                  busy_q  <= 1'b1;
                  fsm_q   <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               if (rnd_q == 4'd0 || rnd_q > 4'(NR - 1)) begin
                  // Counter corrupted: abandon the block quietly.
                  rnd_q  <= '0;
                  busy_q <= 1'b0;
                  fsm_q  <= ST_IDLE;
               end else begin
                  state_q <= round_d;
                  rnd_q   <= rnd_q - 4'd1;
                  if (rnd_q == 4'd1) fsm_q <= ST_FINAL;
               end
            end
            ST_FINAL: begin
               pt_q   <= round_d;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               fsm_q  <= ST_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               fsm_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign plaintext = pt_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
